// File: rtl/buf_seg_sequencer_pkg.sv
// Shared types and constants for the buffer segment sequencer.
package buf_seg_sequencer_pkg;

    // Width of the segment count and target (supports up to 15 segments).
    localparam int CNT_W    = 4;
    localparam int NSEG_DEF = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RAMP = 1'b1
    } state_e;

    // Limit a requested segment count to the number of segments present.
    function automatic logic [CNT_W-1:0] clamp_tgt(input logic [CNT_W-1:0] tgt,
                                                   input logic [CNT_W-1:0] lim);
        return (tgt > lim) ? lim : tgt;
    endfunction

endpackage

// File: rtl/buf_seg_therm.sv
// Thermometer decode of the enabled-segment count into per-segment enables.
module buf_seg_therm
    import buf_seg_sequencer_pkg::*;
#(
    parameter int NSEG = NSEG_DEF
) (
    input  logic [CNT_W-1:0] cnt_i,
    output logic [NSEG-1:0]  seg_en_o
);

    // Segment g is on whenever more than g segments are counted.
    for (genvar g = 0; g < NSEG; g++) begin : g_seg
        assign seg_en_o[g] = (cnt_i > CNT_W'(g));
    end

endmodule

// File: rtl/buf_seg_sequencer.sv
// Ramps the number of enabled buffer segments one step at a time toward a
// target, with a programmable dwell between steps and an emergency shutdown.
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   ST_IDLE | count equals target, waiting for an update strobe
//   ST_RAMP | stepping count toward target, one step per DWELL+1 cycles
module buf_seg_sequencer
    import buf_seg_sequencer_pkg::*;
#(
    parameter int NSEG    = NSEG_DEF,
    parameter int DWELL_W = 4
) (
    input  logic               clk_i,
    input  logic               rn_i,
    input  logic               upd_i,
    input  logic [CNT_W-1:0]   tgt_i,
    input  logic [DWELL_W-1:0] dwell_i,
    input  logic               shdn_i,
    output logic [NSEG-1:0]    seg_en_o,
    output logic [CNT_W-1:0]   cnt_o,
    output logic               busy_o,
    output logic               done_o
);

    localparam logic [CNT_W-1:0] NSEG_C = CNT_W'(NSEG);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   tgt_q, tgt_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic               done_q, done_d;

    logic [CNT_W-1:0]   tgt_clamped;
    logic [CNT_W-1:0]   tgt_eff;

    // State and datapath registers; reset abandons any ramp in progress.
    always_ff @(posedge clk_i or negedge rn_i) begin
        if (!rn_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            tgt_q   <= '0;
            dwell_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tgt_q   <= tgt_d;
            dwell_q <= dwell_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic: shutdown first, then update/retarget, then stepping.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        tgt_d       = tgt_q;
        dwell_d     = dwell_q;
        done_d      = 1'b0;
        tgt_clamped = clamp_tgt(tgt_i, NSEG_C);
        tgt_eff     = tgt_q;

        if (shdn_i) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            tgt_d   = '0;
            dwell_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (upd_i) begin
                        tgt_d = tgt_clamped;
                        if (tgt_clamped != cnt_q) begin
                            dwell_d = dwell_i;
                            state_d = ST_RAMP;
                        end else begin
                            done_d = 1'b1;
                        end
                    end
                end
                ST_RAMP: begin
                    // A retarget takes effect on the same edge; the dwell
                    // counter keeps its phase.
                    if (upd_i) begin
                        tgt_eff = tgt_clamped;
                        tgt_d   = tgt_clamped;
                    end
                    if (tgt_eff == cnt_q) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else if (dwell_q != '0) begin
                        dwell_d = dwell_q - DWELL_W'(1);
                    end else begin
                        cnt_d   = (tgt_eff > cnt_q) ? cnt_q + CNT_W'(1)
                                                    : cnt_q - CNT_W'(1);
                        dwell_d = dwell_i;
                        if (cnt_d == tgt_eff) begin
                            state_d = ST_IDLE;
                            done_d  = 1'b1;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign cnt_o  = cnt_q;
    assign busy_o = (state_q == ST_RAMP);
    assign done_o = done_q;

    buf_seg_therm #(
        .NSEG(NSEG)
    ) u_therm (
        .cnt_i   (cnt_q),
        .seg_en_o(seg_en_o)
    );

endmodule

// File: tb/tb_buf_seg_sequencer.sv
// Directed bench for buf_seg_sequencer: ramp up, retargeted ramp down,
// clamping/no-op update, shutdown and asynchronous reset.
module tb_buf_seg_sequencer;

    logic       clk_i = 1'b0;
    logic       rn_i;
    logic       upd_i;
    logic [3:0] tgt_i;
    logic [3:0] dwell_i;
    logic       shdn_i;
    logic [7:0] seg_en_o;
    logic [3:0] cnt_o;
    logic       busy_o;
    logic       done_o;

    int checks   = 0;
    int failures = 0;
    int done_seen;

    // Enables expected for counts 0..8.
    logic [7:0] therm_tab [0:8] = '{8'h00, 8'h01, 8'h03, 8'h07, 8'h0F,
                                    8'h1F, 8'h3F, 8'h7F, 8'hFF};

    buf_seg_sequencer #(
        .NSEG   (8),
        .DWELL_W(4)
    ) dut (
        .clk_i   (clk_i),
        .rn_i    (rn_i),
        .upd_i   (upd_i),
        .tgt_i   (tgt_i),
        .dwell_i (dwell_i),
        .shdn_i  (shdn_i),
        .seg_en_o(seg_en_o),
        .cnt_o   (cnt_o),
        .busy_o  (busy_o),
        .done_o  (done_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        rn_i = 1'b0; upd_i = 1'b0; tgt_i = 4'd0; dwell_i = 4'd0; shdn_i = 1'b0;
        #12;
        chk("rst_cnt",  32'(cnt_o),    32'd0);
        chk("rst_seg",  32'(seg_en_o), 32'h00);
        chk("rst_busy", 32'(busy_o),   32'd0);
        chk("rst_done", 32'(done_o),   32'd0);
        rn_i = 1'b1;

        // Ramp up 0 -> 8 with DWELL=2: steps at edges 3,6,...,24.
        dwell_i = 4'd2; tgt_i = 4'd8; upd_i = 1'b1;
        tick();
        upd_i = 1'b0;
        chk("up_start_cnt",  32'(cnt_o),  32'd0);
        chk("up_start_busy", 32'(busy_o), 32'd1);
        done_seen = 0;
        for (int e = 1; e <= 24; e++) begin
            tick();
            chk("up_cnt", 32'(cnt_o), 32'(e / 3));
            if (e % 3 == 0) chk("up_seg", 32'(seg_en_o), 32'(therm_tab[e / 3]));
            if (e < 24) chk("up_busy", 32'(busy_o), 32'd1);
            done_seen += int'(done_o);
        end
        chk("up_end_done", 32'(done_o), 32'd1);
        chk("up_end_busy", 32'(busy_o), 32'd0);
        tick();
        done_seen += int'(done_o);
        chk("up_done_once", 32'(done_seen), 32'd1);
        chk("up_hold_cnt",  32'(cnt_o),     32'd8);

        // Ramp down to 2 with DWELL=0, retarget to 5 while at 6.
        dwell_i = 4'd0; tgt_i = 4'd2; upd_i = 1'b1;
        tick();
        upd_i = 1'b0;
        chk("dn_start_cnt", 32'(cnt_o), 32'd8);
        done_seen = 0;
        tick();
        chk("dn_cnt7", 32'(cnt_o), 32'd7);
        done_seen += int'(done_o);
        tick();
        chk("dn_cnt6", 32'(cnt_o), 32'd6);
        done_seen += int'(done_o);
        tgt_i = 4'd5; upd_i = 1'b1;
        tick();
        upd_i = 1'b0;
        chk("dn_cnt5",  32'(cnt_o),    32'd5);
        chk("dn_seg5",  32'(seg_en_o), 32'h1F);
        chk("dn_busy",  32'(busy_o),   32'd0);
        done_seen += int'(done_o);
        tick();
        done_seen += int'(done_o);
        chk("dn_hold_cnt",  32'(cnt_o),     32'd5);
        chk("dn_done_once", 32'(done_seen), 32'd1);

        // Target 15 clamps to 8: three single-cycle steps from 5.
        tgt_i = 4'd15; upd_i = 1'b1;
        tick();
        upd_i = 1'b0;
        tick(); chk("cl_cnt6", 32'(cnt_o), 32'd6);
        tick(); chk("cl_cnt7", 32'(cnt_o), 32'd7);
        tick(); chk("cl_cnt8", 32'(cnt_o), 32'd8);
        chk("cl_done", 32'(done_o), 32'd1);
        tick();
        chk("cl_hold_cnt", 32'(cnt_o), 32'd8);

        // Update to the current count: no step, one DONE cycle, never busy.
        tgt_i = 4'd8; upd_i = 1'b1;
        tick();
        upd_i = 1'b0;
        chk("nop_done", 32'(done_o), 32'd1);
        chk("nop_busy", 32'(busy_o), 32'd0);
        chk("nop_cnt",  32'(cnt_o),  32'd8);
        tick();
        chk("nop_done_off", 32'(done_o), 32'd0);
        chk("nop_busy2",    32'(busy_o), 32'd0);

        // Shutdown mid-ramp at count 4, with a simultaneous update.
        tgt_i = 4'd0; upd_i = 1'b1;
        tick();
        upd_i = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        chk("sd_pre_cnt",  32'(cnt_o),  32'd4);
        chk("sd_pre_busy", 32'(busy_o), 32'd1);
        shdn_i = 1'b1; upd_i = 1'b1; tgt_i = 4'd8;
        tick();
        shdn_i = 1'b0; upd_i = 1'b0;
        chk("sd_cnt",  32'(cnt_o),    32'd0);
        chk("sd_seg",  32'(seg_en_o), 32'h00);
        chk("sd_busy", 32'(busy_o),   32'd0);
        chk("sd_done", 32'(done_o),   32'd0);
        tick();
        chk("sd_stay_cnt",  32'(cnt_o),  32'd0);
        chk("sd_stay_busy", 32'(busy_o), 32'd0);

        // Asynchronous reset between edges at count 5.
        dwell_i = 4'd0; tgt_i = 4'd8; upd_i = 1'b1;
        tick();
        upd_i = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        chk("ar_pre_cnt", 32'(cnt_o),    32'd5);
        chk("ar_pre_seg", 32'(seg_en_o), 32'h1F);
        #2 rn_i = 1'b0;
        #1;
        chk("ar_seg",  32'(seg_en_o), 32'h00);
        chk("ar_cnt",  32'(cnt_o),    32'd0);
        chk("ar_busy", 32'(busy_o),   32'd0);
        #2 rn_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("ar_idle_cnt",  32'(cnt_o),  32'd0);
            chk("ar_idle_busy", 32'(busy_o), 32'd0);
            chk("ar_idle_done", 32'(done_o), 32'd0);
        end
        tgt_i = 4'd1; upd_i = 1'b1;
        tick();
        upd_i = 1'b0;
        tick();
        chk("ar_resume_cnt",  32'(cnt_o),  32'd1);
        chk("ar_resume_done", 32'(done_o), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
